spi_target: RTL

- SPI mode-0 responder (target) for the cartridge FPGA: the far end of the SPI controller's exchange transfers, used for an external microcontroller link to FPGA-side logic.
- Samples the bus (SPIClk, nSPISel, SPIDi) through synchronizers into the single system clock; all logic is in the Clk domain.
- Deframes MSB-first bytes into a strobed RX byte stream and serializes a TX holding register onto SPIDo.
- Reports frame start/end and TX underrun.

---
 rtl/spi_target.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/spi_target.sv
// SPI mode-0 target. SPIClk, nSPISel and SPIDi are brought into the Clk domain
// through equal-depth synchronizers. Received bytes are deframed MSB-first into
// RXData, and a one-byte holding register is serialized onto SPIDo.
module spi_target #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic       SPIClk,
  input  logic       nSPISel,
  input  logic       SPIDi,
  output logic       SPIDo,
  output logic       SPIDoEn,
  output logic [7:0] RXData,
  output logic       RXValid,
  input  logic [7:0] TXData,
  input  logic       TXLoad,
  output logic       TXReady,
  output logic       FrameStart,
  output logic       FrameEnd,
  output logic       TXUnderrun
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state_reg, state_next;
  logic [SYNC_STAGES-1:0] sclk_sync_reg, nsel_sync_reg, di_sync_reg, vld_sync_reg;
  logic                   sclk_prev_reg;
  logic                   armed_reg;
  logic [2:0]             bit_cnt_reg, bit_cnt_next;
  logic [7:0]             rx_shift_reg, rx_shift_next;
  logic [7:0]             tx_shift_reg, tx_shift_next;
  logic [7:0]             rx_data_reg, rx_data_next;
  logic                   rx_valid_reg, rx_valid_next;
  logic                   do_reg, do_next;
  logic                   do_en_reg, do_en_next;
  logic                   frame_start_reg, frame_start_next;
  logic                   frame_end_reg, frame_end_next;
  logic                   underrun_reg, underrun_next;
  logic [7:0]             hold_reg;
  logic                   hold_full_reg;
  logic                   reload, consume, accept;
  logic                   sclk_s, nsel_s, di_s, sclk_rise, sclk_fall;
  logic [7:0]             tx_load_byte;

  assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
  assign nsel_s    = nsel_sync_reg[SYNC_STAGES-1];
  assign di_s      = di_sync_reg[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_reg;
  assign sclk_fall = ~sclk_s & sclk_prev_reg;

  // Byte presented at frame start or at a byte boundary.
  assign tx_load_byte = hold_full_reg ? hold_reg : IDLE_BYTE;
  assign consume      = reload & hold_full_reg;
  // A load in the cycle the register is consumed is taken after the consume.
  assign accept       = TXLoad & (~hold_full_reg | consume);

  // Synchronizers, preset to the idle bus. The valid chain marks when the
  // select synchronizer holds a real sample rather than its reset preset, so a
  // select already low at reset release cannot be mistaken for a frame start.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      sclk_sync_reg <= '0;
      nsel_sync_reg <= '1;
      di_sync_reg   <= '0;
      vld_sync_reg  <= '0;
      sclk_prev_reg <= 1'b0;
      armed_reg     <= 1'b0;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], SPIClk};
      nsel_sync_reg <= {nsel_sync_reg[SYNC_STAGES-2:0], nSPISel};
      di_sync_reg   <= {di_sync_reg[SYNC_STAGES-2:0], SPIDi};
      vld_sync_reg  <= {vld_sync_reg[SYNC_STAGES-2:0], 1'b1};
      sclk_prev_reg <= sclk_s;
      armed_reg     <= armed_reg | (vld_sync_reg[SYNC_STAGES-1] & nsel_s);
    end
  end

  // Frame state machine and shift datapath: next-state and output decode.
  always_comb begin
    state_next       = state_reg;
    bit_cnt_next     = bit_cnt_reg;
    rx_shift_next    = rx_shift_reg;
    tx_shift_next    = tx_shift_reg;
    rx_data_next     = rx_data_reg;
    rx_valid_next    = 1'b0;
    do_next          = do_reg;
    do_en_next       = do_en_reg;
    frame_start_next = 1'b0;
    frame_end_next   = 1'b0;
    reload           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (armed_reg && !nsel_s) begin
          state_next       = ACTIVE;
          frame_start_next = 1'b1;
          do_en_next       = 1'b1;
          bit_cnt_next     = 3'd0;
          rx_shift_next    = 8'h00;
          reload           = 1'b1;
        end
      end
      ACTIVE: begin
        if (nsel_s) begin
          // Deselect wins over any SPIClk edge seen in the same cycle.
          state_next     = IDLE;
          frame_end_next = 1'b1;
          do_en_next     = 1'b0;
          do_next        = 1'b1;
          bit_cnt_next   = 3'd0;
          rx_shift_next  = 8'h00;
        end else if (sclk_rise) begin
          rx_shift_next = {rx_shift_reg[6:0], di_s};
          bit_cnt_next  = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            rx_data_next  = {rx_shift_reg[6:0], di_s};
            rx_valid_next = 1'b1;
          end
        end else if (sclk_fall) begin
          if (bit_cnt_reg != 3'd0) begin
            tx_shift_next = {tx_shift_reg[6:0], 1'b0};
            do_next       = tx_shift_reg[6];
          end else begin
            reload = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    underrun_next = reload & ~hold_full_reg;
    if (reload) begin
      tx_shift_next = tx_load_byte;
      do_next       = tx_load_byte[7];
    end
  end

  // State and datapath registers.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_reg       <= IDLE;
      bit_cnt_reg     <= 3'd0;
      rx_shift_reg    <= 8'h00;
      tx_shift_reg    <= 8'h00;
      rx_data_reg     <= 8'h00;
      rx_valid_reg    <= 1'b0;
      do_reg          <= 1'b1;
      do_en_reg       <= 1'b0;
      frame_start_reg <= 1'b0;
      frame_end_reg   <= 1'b0;
      underrun_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      bit_cnt_reg     <= bit_cnt_next;
      rx_shift_reg    <= rx_shift_next;
      tx_shift_reg    <= tx_shift_next;
      rx_data_reg     <= rx_data_next;
      rx_valid_reg    <= rx_valid_next;
      do_reg          <= do_next;
      do_en_reg       <= do_en_next;
      frame_start_reg <= frame_start_next;
      frame_end_reg   <= frame_end_next;
      underrun_reg    <= underrun_next;
    end
  end

  // TX holding register: capture when empty, or when emptied this same cycle.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      hold_reg      <= 8'h00;
      hold_full_reg <= 1'b0;
    end else if (accept) begin
      hold_reg      <= TXData;
      hold_full_reg <= 1'b1;
    end else if (consume) begin
      hold_full_reg <= 1'b0;
    end
  end

  assign SPIDo      = do_reg;
  assign SPIDoEn    = do_en_reg;
  assign RXData     = rx_data_reg;
  assign RXValid    = rx_valid_reg;
  assign TXReady    = ~hold_full_reg;
  assign FrameStart = frame_start_reg;
  assign FrameEnd   = frame_end_reg;
  assign TXUnderrun = underrun_reg;

endmodule
